// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register with valid/ready word load and
// per-load bit order; frames chain back-to-back without a gap cycle.
module piso_shift_reg #(
   parameter int unsigned MSB = 16
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           en,
   input  logic           dir,
   input  logic [MSB-1:0] din,
   input  logic           din_valid,
   output logic           din_ready,
   output logic           q,
   output logic           q_valid,
   output logic           busy,
   output logic           done
);

   localparam int unsigned CW = $clog2(MSB);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MSB - 1);

   logic [0:0]     state_q, state_d;
   logic [MSB-1:0] shreg_q, shreg_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           dir_q, dir_d;
   logic           done_q, done_d;
   logic           last_bit;
   logic           load;

   assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT) && en;
   assign din_ready = (state_q == IDLE) || last_bit;
   assign load      = din_valid && din_ready;

   assign q_valid = (state_q == SHIFT);
   assign busy    = (state_q == SHIFT);
   assign done    = done_q;
   assign q       = q_valid ? (dir_q ? shreg_q[MSB-1] : shreg_q[0]) : 1'b0;

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   // next-state: shift on en, then a load (if any) overrides the shifted word
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
         end
         SHIFT: begin
            if (en) begin
               shreg_d = dir_q ? (shreg_q << 1) : (shreg_q >> 1);
               cnt_d   = cnt_q + CW'(1);
               if (last_bit) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         shreg_d = din;
         dir_d   = dir;
         cnt_d   = '0;
         state_d = SHIFT;
      end
   end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Scoreboard bench for piso_shift_reg: stimulus queues hand-written bit
// sequences and words, a negedge monitor checks q, handshake and loopback words.
module tb_piso_shift_reg;

   localparam int unsigned W = 16;

   logic         clk;
   logic         rstn;
   logic         en;
   logic         dir;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         q;
   logic         q_valid;
   logic         busy;
   logic         done;

   int vectors;
   int miscompares;
   int vcyc;
   int done_cnt;

   logic         exp_bits[$];
   logic [W-1:0] exp_words[$];
   logic         exp_dirs[$];

   piso_shift_reg #(.MSB(W)) dut (
      .clk(clk), .rstn(rstn), .en(en), .dir(dir), .din(din),
      .din_valid(din_valid), .din_ready(din_ready), .q(q),
      .q_valid(q_valid), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: per-cycle handshake checks, bit scoreboard, receiver rebuild
   logic [W-1:0] rx;
   int           k;
   always @(negedge clk) begin
      if (!rstn) begin
         k  = 0;
         rx = '0;
      end else begin
         chk("busy_eq_qvalid", int'(busy), int'(q_valid));
         if (!q_valid) chk("q_idle_zero", int'(q), 0);
         if (done) begin
            done_cnt++;
            chk("done_bitcount", k, W);
            if (exp_words.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               chk("loopback_word", int'(rx), int'(exp_words.pop_front()));
               void'(exp_dirs.pop_front());
            end
            k = 0;
         end
         chk("din_ready", int'(din_ready), int'(!q_valid || (en && k == W - 1)));
         if (q_valid) begin
            vcyc++;
            if (exp_bits.size() == 0) begin
               chk("bit_unexpected", 1, 0);
            end else begin
               chk("q_bit", int'(q), int'(exp_bits[0]));
               if (en) begin
                  void'(exp_bits.pop_front());
                  if (exp_dirs.size() != 0 && exp_dirs[0]) rx = {rx[W-2:0], q};
                  else                                     rx = {q, rx[W-1:1]};
                  k++;
               end
            end
         end
      end
   end

   // seq lists the expected q bits in order, first bit at seq[W-1]
   task automatic load(input logic [W-1:0] w, input logic d, input logic [W-1:0] seq);
      int n;
      din       = w;
      dir       = d;
      din_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (din_ready) break;
         n++;
         if (n > 200) begin
            chk("load_timeout", 1, 0);
            break;
         end
      end
      for (int i = W - 1; i >= 0; i--) exp_bits.push_back(seq[i]);
      exp_words.push_back(w);
      exp_dirs.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (exp_words.size() == 0 && !busy) break;
         n++;
         if (n > 200) begin
            chk("idle_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // asynchronous reset pulse with immediate output checks, then flush
   task automatic reset_pulse();
      rstn = 1'b0;
      #1;
      chk("rst_q", int'(q), 0);
      chk("rst_q_valid", int'(q_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_din_ready", int'(din_ready), 1);
      #10;
      exp_bits.delete();
      exp_words.delete();
      exp_dirs.delete();
      din_valid = 1'b0;
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int v0;
   int d0;

   initial begin
      vectors = 0; miscompares = 0; vcyc = 0; done_cnt = 0;
      rstn = 1'b0; en = 1'b1; dir = 1'b0; din = '0; din_valid = 1'b0;
      #12 rstn = 1'b1;
      @(posedge clk); #1;

      // 1: reset mid-frame with din_valid still high
      load(16'hA5C3, 1'b1, 16'hA5C3);
      repeat (3) @(posedge clk);
      #1;
      reset_pulse();

      // 2: MSB first
      v0 = vcyc; d0 = done_cnt;
      load(16'hA5C3, 1'b1, 16'hA5C3);
      din_valid = 1'b0;
      wait_idle();
      chk("t2_valid_cycles", vcyc - v0, 16);
      chk("t2_done_pulses", done_cnt - d0, 1);
      chk("t2_busy_after", int'(busy), 0);

      // 3: LSB first, dir flipped at bit 4
      v0 = vcyc; d0 = done_cnt;
      load(16'hA5C3, 1'b0, 16'b1100_0011_1010_0101);
      din_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 dir = 1'b1;
      wait_idle();
      chk("t3_valid_cycles", vcyc - v0, 16);
      chk("t3_done_pulses", done_cnt - d0, 1);

      // 4: 3-cycle stall after bit 6
      v0 = vcyc; d0 = done_cnt;
      load(16'h00FF, 1'b1, 16'h00FF);
      din_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 en = 1'b0;
      repeat (3) @(posedge clk);
      #1 en = 1'b1;
      wait_idle();
      chk("t4_valid_cycles", vcyc - v0, 19);
      chk("t4_done_pulses", done_cnt - d0, 1);

      // 5: back-to-back words, din_valid held
      v0 = vcyc; d0 = done_cnt;
      load(16'hFFFF, 1'b1, 16'hFFFF);
      load(16'h0000, 1'b1, 16'h0000);
      din_valid = 1'b0;
      wait_idle();
      chk("t5_valid_cycles", vcyc - v0, 32);
      chk("t5_done_pulses", done_cnt - d0, 2);

      // 6: reset after 5 bits, then clean reload
      d0 = done_cnt;
      load(16'h1234, 1'b1, 16'h1234);
      repeat (5) @(posedge clk);
      #1;
      reset_pulse();
      repeat (3) @(posedge clk);
      #1;
      chk("t6_no_done", done_cnt - d0, 0);
      v0 = vcyc;
      load(16'h1234, 1'b1, 16'h1234);
      din_valid = 1'b0;
      wait_idle();
      chk("t6_valid_cycles", vcyc - v0, 16);
      chk("t6_done_pulses", done_cnt - d0, 1);
      chk("t6_queue_empty", exp_bits.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
